// File: rtl/uart_frame_scheduler_pkg.sv
// rtl/uart_frame_scheduler_pkg.sv - shared states and constants for the UART frame scheduler
package uart_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_NEXT
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int         NUM_SRC  = 2;

endpackage

// File: rtl/uart_frame_scheduler_rr_arb2.sv
// rtl/uart_frame_scheduler_rr_arb2.sv - two-way round-robin pick, combinational
module rr_arb2
  import uart_frame_scheduler_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_pending,
  input  logic               i_last,
  output logic [NUM_SRC-1:0] o_winner
);

  // On a tie the source that was not served last wins; i_last=1 means src1 was last.
  always_comb begin
    o_winner = '0;
    case (i_pending)
      2'b11:   o_winner = i_last ? 2'b01 : 2'b10;
      2'b01:   o_winner = 2'b01;
      2'b10:   o_winner = 2'b10;
      default: o_winner = '0;
    endcase
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - frame-granular round-robin sharing of one UART TX; optional TX_TIMEOUT_EN
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 5,
  parameter int MAX_LEN    = 26,
  parameter int TIMEOUT    = 2000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_SRC-1:0]    i_req,
  input  logic [DATA_WIDTH-1:0] i_src0_data,
  input  logic [DATA_WIDTH-1:0] i_src1_data,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic [IDX_WIDTH-1:0]  o_idx,
  output logic [NUM_SRC-1:0]    o_grant,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic [NUM_SRC-1:0]    o_frame_done,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  state_t                r_state;
  state_t                w_next;
  logic [NUM_SRC-1:0]    r_pending;
  logic                  r_last;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [NUM_SRC-1:0]    r_grant;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [NUM_SRC-1:0]    w_winner;
  logic [NUM_SRC-1:0]    w_clear;
  logic                  w_end;
  logic                  w_tx_start;
  logic                  w_tmo;

  rr_arb2 u_arb (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_winner  (w_winner)
  );

  assign w_clear = (r_state == ST_IDLE) ? w_winner : '0;
  assign w_end   = (r_tx_data == DATA_WIDTH'(ASCII_LF)) ||
                   (r_idx == IDX_WIDTH'(MAX_LEN - 1));

`ifdef TX_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] r_tcnt;

  // Cycle count since START entry; every START is entered from LOAD, so clear there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_tcnt <= '0;
    end else if (r_state == ST_START || r_state == ST_WAIT) begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  // A tx_done landing on the final WAIT cycle still completes the byte.
  assign w_tmo = (r_state == ST_START || r_state == ST_WAIT) && (r_tcnt == TMO_LAST) &&
                 !(r_state == ST_WAIT && i_tx_done);
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state and the start strobe; timeout takes priority over launching a byte.
  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    case (r_state)
      ST_IDLE:  if (|w_winner) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_START;
      ST_START: begin
        if (w_tmo) begin
          w_next = ST_IDLE;
        end else if (!i_tx_busy) begin
          w_tx_start = 1'b1;
          w_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_tmo)          w_next = ST_IDLE;
        else if (i_tx_done) w_next = ST_NEXT;
      end
      ST_NEXT:  w_next = w_end ? ST_IDLE : ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, request bookkeeping, grant, index and byte register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_last    <= 1'b1;
      r_idx     <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_pending & ~w_clear) | i_req;
      case (r_state)
        ST_IDLE: begin
          if (|w_winner) begin
            r_grant <= w_winner;
            r_idx   <= '0;
            r_last  <= w_winner[1];
          end
        end
        ST_LOAD: r_tx_data <= r_grant[0] ? i_src0_data : i_src1_data;
        ST_NEXT: begin
          if (w_end) r_grant <= '0;
          else       r_idx   <= r_idx + 1'b1;
        end
        default: begin
          if (w_tmo) r_grant <= '0;
        end
      endcase
    end
  end

  assign o_idx         = r_idx;
  assign o_grant       = r_grant;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = w_tx_start;
  assign o_frame_done  = (r_state == ST_NEXT && w_end) ? r_grant : '0;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = w_tmo;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed bench with frame-level model for uart_frame_scheduler
module tb_uart_frame_scheduler;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_req = 2'b00;
  logic [7:0] i_src0_data, i_src1_data;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [4:0] o_idx;
  logic [1:0] o_grant;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic [1:0] o_frame_done;
  logic       o_busy;
  logic       o_timeout_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_fd = 0;
  int max_idx = 0;
  int cyc = 0;
  bit lf_mode = 1'b0;
  bit force_busy = 1'b0;
  bit suppress_done = 1'b0;
  string s0_txt = "temp:21.5C hum:40% p:101";

  typedef struct {
    int src;
    int idx;
    int data;
  } exp_t;
  exp_t exp_q[$];
  int   fd_q[$];

  uart_frame_scheduler #(
    .DATA_WIDTH(8), .IDX_WIDTH(5), .MAX_LEN(26), .TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req),
    .i_src0_data(i_src0_data), .i_src1_data(i_src1_data),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_idx(o_idx), .o_grant(o_grant), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_frame_done(o_frame_done),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] src0_byte(input int i);
    if (i < 24)  return s0_txt[i];
    if (i == 24) return 8'h0D;
    if (i == 25) return 8'h0A;
    return 8'h3F;
  endfunction

  function automatic logic [7:0] src1_byte(input int i, input bit lf);
    if (lf && i == 3) return 8'h0A;
    return 8'h61 + 8'(i);
  endfunction

  assign i_src0_data = src0_byte(int'(o_idx));
  assign i_src1_data = src1_byte(int'(o_idx), lf_mode);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Model: a frame is bytes 0.. up to and including the first LF, capped at 26 bytes.
  task automatic push_frame(input int src, input bit with_done);
    exp_t e;
    for (int i = 0; i < 26; i++) begin
      e.src  = src;
      e.idx  = i;
      e.data = int'(src == 0 ? src0_byte(i) : src1_byte(i, lf_mode));
      exp_q.push_back(e);
      if (e.data == 8'h0A) break;
    end
    if (with_done) fd_q.push_back(src);
  endtask

  // UART model: 10-cycle busy after each start, then a done pulse as busy falls.
  always begin
    bit saw;
    int ucnt;
    bit ubusy;
    ubusy = 1'b0;
    ucnt = 0;
    forever begin
      @(negedge clk);
      saw = o_tx_start;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (saw) begin
        ubusy = 1'b1;
        ucnt  = 10;
      end else if (ubusy) begin
        ucnt--;
        if (ucnt == 0) begin
          ubusy = 1'b0;
          if (!suppress_done) tx_done = 1'b1;
        end
      end
      tx_busy = ubusy | force_busy;
    end
  end

  // Every start must match the next modelled byte; every frame_done the next modelled completion.
  always @(negedge clk) begin
    if (!i_rst) begin
      chk("grant_onehot_or_idle", int'(o_grant != 2'b11), 1);
      if (o_tx_start) begin
        exp_t e;
        n_start++;
        if (int'(o_idx) > max_idx) max_idx = int'(o_idx);
        chk("start_while_busy", int'(tx_busy), 0);
        chk("start_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("start_grant", int'(o_grant), e.src == 0 ? 1 : 2);
          chk("start_idx", int'(o_idx), e.idx);
          chk("start_data", int'(o_tx_data), e.data);
        end
      end
      if (o_frame_done != 2'b00) begin
        n_fd++;
        chk("frame_done_expected", int'(fd_q.size() > 0), 1);
        if (fd_q.size() > 0) chk("frame_done_src", int'(o_frame_done), fd_q.pop_front() == 0 ? 1 : 2);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((o_busy || exp_q.size() > 0 || fd_q.size() > 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("idle_within_budget", int'(c < budget), 1);
    chk("model_bytes_consumed", exp_q.size(), 0);
    chk("model_frames_consumed", fd_q.size(), 0);
    chk("grant_idle", int'(o_grant), 0);
  endtask

  task automatic pulse_req(input logic [1:0] r);
    @(posedge clk);
    #1;
    i_req = r;
    @(posedge clk);
    #1;
    i_req = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idx"}, int'(o_idx), 0);
    chk({tag, "_grant"}, int'(o_grant), 0);
    chk({tag, "_tx_data"}, int'(o_tx_data), 0);
    chk({tag, "_tx_start"}, int'(o_tx_start), 0);
    chk({tag, "_frame_done"}, int'(o_frame_done), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_timeout_err"}, int'(o_timeout_err), 0);
  endtask

  initial begin
    int c;
    logic [7:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    i_rst = 1'b0;

    // Single 26-byte src0 frame with latency pins.
    n_start = 0; n_fd = 0;
    push_frame(0, 1'b1);
    @(posedge clk); #1;
    i_req = 2'b01;
    @(posedge clk); #1;
    i_req = 2'b00;
    chk("lat_grant_k", int'(o_grant), 0);
    @(posedge clk); #1;
    chk("lat_grant_k1", int'(o_grant), 1);
    chk("lat_start_k1", int'(o_tx_start), 0);
    @(posedge clk); #1;
    chk("lat_data_k2", int'(o_tx_data), 8'h74);
    chk("lat_start_k2", int'(o_tx_start), 1);
    wait_idle(2000);
    chk("t1_start_count", n_start, 26);
    chk("t1_frame_done_count", n_fd, 1);

    // src1 frame ending early on LF at index 3.
    lf_mode = 1'b1; n_start = 0; n_fd = 0; max_idx = 0;
    push_frame(1, 1'b1);
    pulse_req(2'b10);
    wait_idle(1000);
    chk("t2_start_count", n_start, 4);
    chk("t2_max_idx", max_idx, 3);
    chk("t2_frame_done_count", n_fd, 1);

    // Simultaneous requests twice: src0 then src1 each round, no interleave.
    lf_mode = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n_start = 0;
      push_frame(0, 1'b1);
      push_frame(1, 1'b1);
      pulse_req(2'b11);
      wait_idle(3000);
      chk("t3_start_count", n_start, 52);
    end

    // Back-pressure: START held by tx_busy, byte stays put.
    lf_mode = 1'b1; n_start = 0;
    force_busy = 1'b1;
    push_frame(1, 1'b1);
    pulse_req(2'b10);
    repeat (4) @(negedge clk);
    held = o_tx_data;
    chk("t4_held_byte", int'(held), 8'h61);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      chk("t4_no_start", int'(o_tx_start), 0);
      chk("t4_data_stable", int'(o_tx_data), int'(held));
    end
    force_busy = 1'b0;
    @(posedge clk); #2;
    chk("t4_start_after_release", int'(o_tx_start), 1);
    @(posedge clk); #2;
    chk("t4_start_one_cycle", int'(o_tx_start), 0);
    wait_idle(1000);
    chk("t4_start_count", n_start, 4);

    // Reset mid-frame at index 7, with both requests during reset.
    push_frame(0, 1'b1);
    pulse_req(2'b01);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(o_tx_start && o_idx == 5'd7) && c < 500);
    chk("t5_reached_idx7", int'(c < 500), 1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_req = 2'b11;
    exp_q.delete();
    fd_q.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_req = 2'b00;
    chk_reset_outputs("midreset");
    repeat (5) @(posedge clk);
    #1;
    chk("t5_reqs_dropped_busy", int'(o_busy), 0);
    chk("t5_reqs_dropped_grant", int'(o_grant), 0);
    n_fd = 0;
    push_frame(1, 1'b1);
    pulse_req(2'b10);
    wait_idle(1000);
    chk("t5_src1_frame_done", n_fd, 1);

`ifdef TX_TIMEOUT_EN
    // No tx_done: src0 aborts after the timeout, pending src1 then runs.
    begin
      exp_t e;
      int t0;
      int t1;
      suppress_done = 1'b1;
      n_fd = 0;
      e.src = 0; e.idx = 0; e.data = int'(src0_byte(0));
      exp_q.push_back(e);
      pulse_req(2'b11);
      c = 0;
      t0 = 0;
      do begin
        @(negedge clk);
        if (o_tx_start) t0 = cyc;
        c++;
      end while (!o_timeout_err && c < 400);
      t1 = cyc;
      chk("t6_timeout_seen", int'(c < 400), 1);
      chk("t6_timeout_delay", t1 - t0, 99);
      suppress_done = 1'b0;
      push_frame(1, 1'b1);
      @(posedge clk); #1;
      chk("t6_busy_low", int'(o_busy), 0);
      @(posedge clk); #1;
      chk("t6_src1_granted", int'(o_grant), 2);
      wait_idle(1000);
      chk("t6_frame_done_count", n_fd, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
